ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock port clk, reset port rst_n.
REQ-002 Ports SHALL be (name  direction  width  meaning):
 clk  in  1  system clock (the 1 MHz core clock domain)
 rst_n  in  1  asynchronous active-low reset
 m0_req  in  1  core data port request, held until m0_ack
 m0_we  in  1  1=write, 0=read
 m0_addr  in  32  byte address
 m0_type  in  3  rw_type (000 b, 001 h, 010 w, 100 bu, 101 hu)
 m0_wdat  in  32  write data
 m0_ack  out  1  one-cycle completion pulse
 m0_rdat  out  32  read data, valid with m0_ack
 m1_req, m1_we, m1_addr, m1_type, m1_wdat, m1_ack, m1_rdat  same widths/meaning  loader/debug port
 ram_rd_en  out  1  RAM read enable
 ram_wr_en  out  1  RAM write enable
 ram_addr  out  32  RAM address
 ram_rw_type  out  3  RAM access type
 ram_dat_i  out  32  write data to RAM
 ram_dat_o  in  32  read data from RAM, valid one cycle after ram_rd_en
REQ-003 No parameters; widths fixed as listed.

Function
REQ-004 FSM states SHALL be IDLE, ACC, RESP; one transaction per 3 cycles; no pipelining.
REQ-005 IDLE: if any m*_req high at edge T, SHALL pick winner, latch its we/addr/type/wdat and index, and enter ACC at T+1.
REQ-006 Arbitration SHALL be round-robin, two requesters: if both request, grant the one not granted last; a single requester always wins; pointer after reset favours m0.
REQ-007 ACC (exactly one cycle): ram_addr/ram_rw_type/ram_dat_i SHALL equal the latched values; ram_rd_en=~we or ram_wr_en=we, never both.
REQ-008 RESP (exactly one cycle): winner's ack SHALL be 1; for reads, the winner's rdat SHALL be loaded from ram_dat_o and held until that master's next read completes; writes leave rdat unchanged.
REQ-009 RESP SHALL always return to IDLE; the acked master's req, still high in RESP, SHALL NOT start a new grant.
REQ-010 Latency request-seen to ack SHALL be 2 cycles (ack at T+2); the loser waits at most one full transaction plus 1 cycle.
REQ-011 Request inputs SHALL be sampled only in IDLE; changes or deassertion of req during ACC/RESP SHALL be ignored and the latched transaction SHALL complete with ack.
REQ-012 Illegal type (011, 110, 111): SHALL pass ACC with both RAM enables 0 and SHALL ack in RESP with rdat forced to 0; the pointer SHALL still advance.
REQ-013 Address alignment SHALL NOT be checked; addr passes unchanged.
REQ-014 At most one ack SHALL be high per cycle; the non-winner's ack SHALL stay 0.
REQ-015 Outside ACC, ram_rd_en and ram_wr_en SHALL be 0; ram_addr/ram_rw_type/ram_dat_i hold their last values.

Reset
REQ-016 On rst_n low, without waiting for a clock edge: state=IDLE, pointer favours m0, all acks 0, RAM enables 0, ram_addr/ram_rw_type/ram_dat_i/m0_rdat/m1_rdat = 0.
REQ-017 Reset during ACC or RESP SHALL abort the transaction with no ack; an ACC write may or may not have reached the RAM.
REQ-018 The first grant after rst_n rises SHALL be sampled no earlier than the first rising clk edge.

Structure
REQ-019 A shared package ram_arb_pkg SHALL hold the state enum, rw_type encodings and master-index constants.
REQ-020 The round-robin pointer and grant logic SHALL be the sub-module rr_arb2 (inputs req[1:0], advance; output grant index).
REQ-021 All outputs SHALL be driven from registers.

Verification
REQ-022 Single m0 read, addr 0x10, type 010, RAM returns 0xDEADBEEF -> ram_rd_en at T+1, m0_ack and m0_rdat=0xDEADBEEF at T+2, m1_ack stays 0.
REQ-023 m0 and m1 both request from reset -> m0 served first (ack T+2), m1 served next (ack T+5); repeated contention alternates m1, m0.
REQ-024 m1 write addr 0x20, data 0x12345678, type 000 -> ram_wr_en=1, ram_rw_type=000, ram_dat_i=0x12345678 during ACC; m1_ack at T+2; m1_rdat unchanged.
REQ-025 m0 request with type 111 -> no RAM enable in ACC, m0_ack at T+2 with m0_rdat=0.
REQ-026 rst_n pulsed low during ACC -> enables and acks drop immediately, state IDLE, no ack; a request after release completes normally with 2-cycle latency.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter.
//   state_t     : transaction FSM states (IDLE -> ACC -> RESP -> IDLE)
//   RW_*        : access-type encodings carried on the rw_type lines
//   M0 / M1     : master index constants used by the grant logic
//   is_legal()  : true for the five defined access types
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] RW_B  = 3'b000;
    localparam logic [2:0] RW_H  = 3'b001;
    localparam logic [2:0] RW_W  = 3'b010;
    localparam logic [2:0] RW_BU = 3'b100;
    localparam logic [2:0] RW_HU = 3'b101;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    function automatic logic is_legal(input logic [2:0] t);
        return (t == RW_B) || (t == RW_H) || (t == RW_W) ||
               (t == RW_BU) || (t == RW_HU);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// One master-side RAM access port.
//   req/we/addr/rw_type/wdat : request, held by the master until ack
//   ack                      : one-cycle completion pulse
//   rdat                     : read data, valid with ack, held until next read
// Modports: master (the requester), slave (the arbiter).
interface ram_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  rw_type;
    logic [31:0] wdat;
    logic        ack;
    logic [31:0] rdat;

    modport master (output req, we, addr, rw_type, wdat, input ack, rdat);
    modport slave  (input req, we, addr, rw_type, wdat, output ack, rdat);
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin grant.
//   clk, rst_n : clock, async active-low reset
//   req[1:0]   : request vector, bit i = master i
//   advance    : a grant is being taken this cycle; move priority on
//   grant      : index of the winning master (meaningful when |req)
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant
);
    // pri = master that wins a tie; after reset m0 is favoured
    logic pri;

    // A lone requester always wins; on a tie the priority holder wins.
    always_comb grant = (req == 2'b11) ? pri : req[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pri <= 1'b0;
        else if (advance) pri <= ~grant;
    end
endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two masters onto one single-port RAM, one transaction at a time.
//   clk, rst_n        : clock, async active-low reset
//   m0, m1            : master ports (slave modport), m0 = core, m1 = loader
//   ram_rd_en/wr_en   : RAM strobes, high only in the ACC cycle
//   ram_addr/rw_type/dat_i : latched request, held after the access
//   ram_dat_o         : RAM read data, sampled at the edge ending ACC
// Every transaction takes IDLE -> ACC -> RESP; ack lands two edges after
// the edge that sampled the request. All outputs come from flops.
module ram_arbiter
    import ram_arb_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    ram_arbiter_if.slave   m0,
    ram_arbiter_if.slave   m1,
    output logic           ram_rd_en,
    output logic           ram_wr_en,
    output logic [31:0]    ram_addr,
    output logic [2:0]     ram_rw_type,
    output logic [31:0]    ram_dat_i,
    input  logic [31:0]    ram_dat_o
);
    state_t      state;
    logic [1:0]  req;
    logic        advance;
    logic        grant;
    logic        idx;
    logic        we_q;

    logic        sel_we;
    logic [31:0] sel_addr;
    logic [2:0]  sel_type;
    logic [31:0] sel_wdat;

    // Requests only matter in IDLE, so anything seen in ACC/RESP is ignored.
    assign req     = {m1.req, m0.req};
    assign advance = (state == IDLE) && (|req);

    rr_arb2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        sel_we   = (grant == M1) ? m1.we      : m0.we;
        sel_addr = (grant == M1) ? m1.addr    : m0.addr;
        sel_type = (grant == M1) ? m1.rw_type : m0.rw_type;
        sel_wdat = (grant == M1) ? m1.wdat    : m0.wdat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= M0;
            we_q        <= 1'b0;
            ram_rd_en   <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_addr    <= '0;
            ram_rw_type <= '0;
            ram_dat_i   <= '0;
            m0.ack      <= 1'b0;
            m1.ack      <= 1'b0;
            m0.rdat     <= '0;
            m1.rdat     <= '0;
        end else begin
            ram_rd_en <= 1'b0;
            ram_wr_en <= 1'b0;
            m0.ack    <= 1'b0;
            m1.ack    <= 1'b0;
            case (state)
                IDLE: if (advance) begin
                    state       <= ACC;
                    idx         <= grant;
                    we_q        <= sel_we;
                    // The RAM bus registers double as the transaction latch.
                    ram_addr    <= sel_addr;
                    ram_rw_type <= sel_type;
                    ram_dat_i   <= sel_wdat;
                    ram_rd_en   <= is_legal(sel_type) && !sel_we;
                    ram_wr_en   <= is_legal(sel_type) && sel_we;
                end
                ACC: begin
                    state <= RESP;
                    if (idx == M1) m1.ack <= 1'b1;
                    else           m0.ack <= 1'b1;
                    // Illegal types return zero; writes keep the old rdat.
                    if (!is_legal(ram_rw_type)) begin
                        if (idx == M1) m1.rdat <= '0;
                        else           m0.rdat <= '0;
                    end else if (!we_q) begin
                        if (idx == M1) m1.rdat <= ram_dat_o;
                        else           m0.rdat <= ram_dat_o;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_arbiter_if m0_bus ();
    ram_arbiter_if m1_bus ();

    logic        ram_rd_en, ram_wr_en;
    logic [31:0] ram_addr, ram_dat_i, ram_dat_o;
    logic [2:0]  ram_rw_type;

    ram_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0          (m0_bus),
        .m1          (m1_bus),
        .ram_rd_en   (ram_rd_en),
        .ram_wr_en   (ram_wr_en),
        .ram_addr    (ram_addr),
        .ram_rw_type (ram_rw_type),
        .ram_dat_i   (ram_dat_i),
        .ram_dat_o   (ram_dat_o)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit          legal_tab [8] = '{1, 1, 1, 0, 1, 1, 0, 0};
    bit          pri;              // master that wins the next tie
    logic [31:0] exp_rdat [2];
    logic [31:0] last_addr, last_dat;
    logic [2:0]  last_type;
    bit          r_we   [2];
    logic [31:0] r_addr [2];
    logic [2:0]  r_type [2];
    logic [31:0] r_wdat [2];
    logic [31:0] next_ram_dat;
    bit          allow_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int m, input bit on);
        if (m == 0) begin
            m0_bus.req = on; m0_bus.we = r_we[0]; m0_bus.addr = r_addr[0];
            m0_bus.rw_type = r_type[0]; m0_bus.wdat = r_wdat[0];
        end else begin
            m1_bus.req = on; m1_bus.we = r_we[1]; m1_bus.addr = r_addr[1];
            m1_bus.rw_type = r_type[1]; m1_bus.wdat = r_wdat[1];
        end
    endtask

    task automatic fill_rand(input int m);
        r_we[m]   = $urandom_range(0, 1);
        r_addr[m] = $urandom;
        r_type[m] = 3'($urandom_range(0, 7));
        r_wdat[m] = $urandom;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rd_en"}, ram_rd_en, 0);
        chk({tag, "_wr_en"}, ram_wr_en, 0);
        chk({tag, "_acks"}, {m1_bus.ack, m0_bus.ack}, 0);
        chk({tag, "_addr_hold"}, ram_addr, last_addr);
        chk({tag, "_type_hold"}, ram_rw_type, last_type);
    endtask

    // Called at the negedge inside the ACC cycle of master w.
    task automatic serve(input int w);
        bit lg = legal_tab[r_type[w]];
        chk("acc_rd_en", ram_rd_en, lg && !r_we[w]);
        chk("acc_wr_en", ram_wr_en, lg && r_we[w]);
        chk("acc_addr", ram_addr, r_addr[w]);
        chk("acc_type", ram_rw_type, r_type[w]);
        chk("acc_dat_i", ram_dat_i, r_wdat[w]);
        chk("acc_acks", {m1_bus.ack, m0_bus.ack}, 0);
        last_addr = r_addr[w]; last_type = r_type[w]; last_dat = r_wdat[w];
        ram_dat_o = next_ram_dat;
        if (allow_drop && $urandom_range(0, 1) == 1) drive(w, 1'b0);
        if (!lg)           exp_rdat[w] = 0;
        else if (!r_we[w]) exp_rdat[w] = next_ram_dat;
        @(negedge clk);
        chk(w == 0 ? "resp_m0_ack" : "resp_m1_ack", w == 0 ? m0_bus.ack : m1_bus.ack, 1);
        chk("resp_other_ack", w == 0 ? m1_bus.ack : m0_bus.ack, 0);
        chk("resp_enables", {ram_rd_en, ram_wr_en}, 0);
        chk("resp_m0_rdat", m0_bus.rdat, exp_rdat[0]);
        chk("resp_m1_rdat", m1_bus.rdat, exp_rdat[1]);
        drive(w, 1'b0);
        next_ram_dat = $urandom;
    endtask

    // One request burst from the IDLE state; both masters may ask at once.
    task automatic round(input bit q0, input bit q1);
        int first, second;
        @(negedge clk);
        chk_quiet("idle");
        if (q0) drive(0, 1'b1);
        if (q1) drive(1, 1'b1);
        if (q0 && q1) begin first = pri; second = 1 - int'(pri); end
        else begin first = q1 ? 1 : 0; second = -1; end
        pri = (first == 0);
        @(negedge clk);
        serve(first);
        if (second >= 0) begin
            @(negedge clk);
            chk_quiet("gap");
            pri = (second == 0);
            @(negedge clk);
            serve(second);
        end
    endtask

    task automatic model_reset();
        pri = 0; exp_rdat[0] = 0; exp_rdat[1] = 0;
        last_addr = 0; last_type = 0; last_dat = 0;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) fill_rand(m);
        drive(0, 1'b0); drive(1, 1'b0);
        ram_dat_o = 0; next_ram_dat = 32'hDEADBEEF; allow_drop = 0;
        model_reset();
        rst_n = 0;
        #1;
        chk("rst_rd_en", ram_rd_en, 0);
        chk("rst_acks", {m1_bus.ack, m0_bus.ack}, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_rdat", {m0_bus.rdat | m1_bus.rdat}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Single m0 word read returning DEADBEEF
        r_we[0] = 0; r_addr[0] = 32'h10; r_type[0] = 3'b010;
        round(1, 0);
        chk("dir_m0_rdat", m0_bus.rdat, 32'hDEADBEEF);

        // Contention straight after reset: m0 first, then m1
        model_reset();
        @(negedge clk); rst_n = 0; @(negedge clk); rst_n = 1;
        fill_rand(0); fill_rand(1);
        round(1, 1);
        // Repeated contention alternates
        fill_rand(0); fill_rand(1);
        round(1, 1);
        fill_rand(0); fill_rand(1);
        round(1, 1);

        // m1 byte write
        r_we[1] = 1; r_addr[1] = 32'h20; r_type[1] = 3'b000; r_wdat[1] = 32'h12345678;
        round(0, 1);

        // Illegal type on m0
        r_we[0] = 0; r_type[0] = 3'b111; r_addr[0] = 32'h33;
        round(1, 0);
        chk("illegal_rdat", m0_bus.rdat, 0);

        // Reset during ACC aborts the transaction
        @(negedge clk);
        fill_rand(0); r_type[0] = 3'b010; r_we[0] = 0;
        drive(0, 1'b1);
        @(negedge clk);
        chk("pre_abort_rd_en", ram_rd_en, 1);
        rst_n = 0;
        #1;
        chk("abort_rd_en", ram_rd_en, 0);
        chk("abort_acks", {m1_bus.ack, m0_bus.ack}, 0);
        chk("abort_addr", ram_addr, 0);
        chk("abort_rdat", {m0_bus.rdat | m1_bus.rdat}, 0);
        drive(0, 1'b0);
        model_reset();
        @(negedge clk);
        chk("abort_no_ack", {m1_bus.ack, m0_bus.ack}, 0);
        rst_n = 1;
        fill_rand(0); r_type[0] = 3'b010; r_we[0] = 0;
        round(1, 0);

        // Randomized traffic, with occasional req drop mid-transaction
        allow_drop = 1;
        for (int i = 0; i < 40; i++) begin
            int pat = $urandom_range(1, 3);
            fill_rand(0); fill_rand(1);
            round(pat[0], pat[1]);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
